// File: rtl/can_pkg.sv
// Shared CAN definitions for the ACK-field receiver: state encoding and bus levels.
package can_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACK_SLOT  = 2'd1,
        ST_ACK_DELIM = 2'd2,
        ST_DONE      = 2'd3
    } ack_rx_state_t;

    localparam logic DOMINANT       = 1'b0;
    localparam logic RECESSIVE      = 1'b1;
    localparam int   ACK_FIELD_BITS = 2;

endpackage

// File: rtl/bit_timeout_counter.sv
// Counts clock cycles between sample points while running; flags the cycle whose
// edge would bring the count to TIMEOUT_CYCLES so the caller can act on that edge.
module bit_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n || clear || !run) begin
            count <= '0;
        end else begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/ack_field_rx.sv
// Receive side of the CAN ACK field: drives the ACK slot as a receiver, checks for
// an acknowledge as transmitter, checks the delimiter and reports results.
//
// state        | meaning
// ST_IDLE      | waiting for start from the CRC stage
// ST_ACK_SLOT  | ACK slot bit in progress, ack_drive may be asserted
// ST_ACK_DELIM | ACK delimiter bit in progress
// ST_DONE      | one-cycle result reporting
module ack_field_rx
    import can_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       sample_point,
    input  logic       rx_bit,
    input  logic       start,
    input  logic       is_transmitter,
    input  logic       crc_ok,
    output logic       ack_drive,
    output logic [1:0] bit_counter,
    output logic       busy,
    output logic       ack_seen,
    output logic       ack_complete,
    output logic       ack_error,
    output logic       form_error,
    output logic       timeout
);

    ack_rx_state_t state, state_nxt;

    logic       tx_q, tx_nxt;
    logic       crc_ok_q, crc_ok_nxt;
    logic       ack_drive_nxt;
    logic [1:0] bit_counter_nxt;
    logic       busy_nxt;
    logic       ack_seen_nxt;
    logic       ack_complete_nxt;
    logic       ack_error_nxt;
    logic       form_error_nxt;
    logic       timeout_nxt;
    logic       in_field;
    logic       expired;

    assign in_field = (state == ST_ACK_SLOT) || (state == ST_ACK_DELIM);

    bit_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .run     (in_field),
        .clear   (sample_point || !enable),
        .expired (expired)
    );

    always_comb begin
        state_nxt        = state;
        tx_nxt           = tx_q;
        crc_ok_nxt       = crc_ok_q;
        ack_drive_nxt    = ack_drive;
        bit_counter_nxt  = bit_counter;
        ack_seen_nxt     = ack_seen;
        ack_complete_nxt = 1'b0;
        ack_error_nxt    = 1'b0;
        form_error_nxt   = 1'b0;
        timeout_nxt      = 1'b0;

        case (state)
            ST_IDLE: begin
                // A coincident sample_point belongs to the CRC delimiter, so only start matters.
                if (start) begin
                    state_nxt       = ST_ACK_SLOT;
                    tx_nxt          = is_transmitter;
                    crc_ok_nxt      = crc_ok;
                    ack_seen_nxt    = 1'b0;
                    bit_counter_nxt = 2'd0;
                    ack_drive_nxt   = !is_transmitter && crc_ok;
                end
            end
            ST_ACK_SLOT: begin
                if (sample_point) begin
                    state_nxt       = ST_ACK_DELIM;
                    ack_seen_nxt    = (rx_bit == DOMINANT);
                    bit_counter_nxt = 2'd1;
                    ack_drive_nxt   = 1'b0;
                end else if (expired) begin
                    state_nxt       = ST_IDLE;
                    timeout_nxt     = 1'b1;
                    ack_drive_nxt   = 1'b0;
                    bit_counter_nxt = 2'd0;
                end else begin
                    ack_drive_nxt   = !tx_q && crc_ok_q;
                end
            end
            ST_ACK_DELIM: begin
                ack_drive_nxt = 1'b0;
                if (sample_point) begin
                    state_nxt        = ST_DONE;
                    bit_counter_nxt  = 2'(ACK_FIELD_BITS);
                    ack_complete_nxt = 1'b1;
                    ack_error_nxt    = tx_q && !ack_seen;
                    form_error_nxt   = (rx_bit == DOMINANT);
                end else if (expired) begin
                    state_nxt       = ST_IDLE;
                    timeout_nxt     = 1'b1;
                    bit_counter_nxt = 2'd0;
                end
            end
            ST_DONE: begin
                state_nxt       = ST_IDLE;
                bit_counter_nxt = 2'd0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_ACK_SLOT) || (state_nxt == ST_ACK_DELIM);
    end

    always_ff @(posedge clock) begin
        if (!reset_n || !enable) begin
            state        <= ST_IDLE;
            tx_q         <= 1'b0;
            crc_ok_q     <= 1'b0;
            ack_drive    <= 1'b0;
            bit_counter  <= 2'd0;
            busy         <= 1'b0;
            ack_seen     <= 1'b0;
            ack_complete <= 1'b0;
            ack_error    <= 1'b0;
            form_error   <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nxt;
            tx_q         <= tx_nxt;
            crc_ok_q     <= crc_ok_nxt;
            ack_drive    <= ack_drive_nxt;
            bit_counter  <= bit_counter_nxt;
            busy         <= busy_nxt;
            ack_seen     <= ack_seen_nxt;
            ack_complete <= ack_complete_nxt;
            ack_error    <= ack_error_nxt;
            form_error   <= form_error_nxt;
            timeout      <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ack_field_rx.sv
// Directed bench for ack_field_rx with TIMEOUT_CYCLES = 8 and hand-computed expectations.
module tb_ack_field_rx;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       sample_point = 1'b0;
    logic       rx_bit = 1'b1;
    logic       start = 1'b0;
    logic       is_transmitter = 1'b0;
    logic       crc_ok = 1'b0;
    logic       ack_drive;
    logic [1:0] bit_counter;
    logic       busy;
    logic       ack_seen;
    logic       ack_complete;
    logic       ack_error;
    logic       form_error;
    logic       timeout;

    int vectors = 0;
    int miscompares = 0;

    // {ack_drive, bit_counter[1:0], busy, ack_seen, ack_complete, ack_error, form_error, timeout}
    logic [8:0] outs;
    assign outs = {ack_drive, bit_counter, busy, ack_seen, ack_complete, ack_error, form_error, timeout};

    ack_field_rx #(.TIMEOUT_CYCLES(8)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .sample_point   (sample_point),
        .rx_bit         (rx_bit),
        .start          (start),
        .is_transmitter (is_transmitter),
        .crc_ok         (crc_ok),
        .ack_drive      (ack_drive),
        .bit_counter    (bit_counter),
        .busy           (busy),
        .ack_seen       (ack_seen),
        .ack_complete   (ack_complete),
        .ack_error      (ack_error),
        .form_error     (form_error),
        .timeout        (timeout)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic tx, input logic ok);
        is_transmitter = tx;
        crc_ok = ok;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_sample(input logic b);
        sample_point = 1'b1;
        rx_bit = b;
        step();
        sample_point = 1'b0;
        rx_bit = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        vectors++;
        if (outs !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outs: got %b want %b", outs, 9'b0);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_receiver_ack();
        do_start(1'b0, 1'b1);
        // drive=1, bc=0, busy=1
        vectors++;
        if (outs !== 9'b1_00_1_00000) begin
            miscompares++;
            $display("FAIL rx_after_start: got %b want %b", outs, 9'b100100000);
        end
        step();
        step();
        sample_point = 1'b1;
        rx_bit = 1'b0;
        #2;
        vectors++;
        if (ack_drive !== 1'b1) begin
            miscompares++;
            $display("FAIL rx_drive_in_sample_cycle: got %b want 1", ack_drive);
        end
        step();
        sample_point = 1'b0;
        rx_bit = 1'b1;
        // drive=0, bc=1, busy=1, seen=1
        vectors++;
        if (outs !== 9'b0_01_1_10000) begin
            miscompares++;
            $display("FAIL rx_after_slot: got %b want %b", outs, 9'b001110000);
        end
        step();
        do_sample(1'b1);
        // bc=2, seen=1, complete=1
        vectors++;
        if (outs !== 9'b0_10_0_11000) begin
            miscompares++;
            $display("FAIL rx_done: got %b want %b", outs, 9'b010011000);
        end
        step();
        vectors++;
        if (outs !== 9'b0_00_0_10000) begin
            miscompares++;
            $display("FAIL rx_after_done: got %b want %b", outs, 9'b000010000);
        end
    endtask

    task automatic test_tx_no_ack();
        do_start(1'b1, 1'b1);
        vectors++;
        if (outs !== 9'b0_00_1_00000) begin
            miscompares++;
            $display("FAIL tx_after_start: got %b want %b", outs, 9'b000100000);
        end
        do_sample(1'b1);
        vectors++;
        if (outs !== 9'b0_01_1_00000) begin
            miscompares++;
            $display("FAIL tx_after_slot: got %b want %b", outs, 9'b001100000);
        end
        do_sample(1'b1);
        // complete=1, ack_error=1
        vectors++;
        if (outs !== 9'b0_10_0_01100) begin
            miscompares++;
            $display("FAIL tx_done: got %b want %b", outs, 9'b010001100);
        end
        step();
    endtask

    task automatic test_form_error();
        do_start(1'b0, 1'b1);
        do_sample(1'b0);
        do_sample(1'b0);
        // seen=1, complete=1, form_error=1
        vectors++;
        if (outs !== 9'b0_10_0_11010) begin
            miscompares++;
            $display("FAIL form_done: got %b want %b", outs, 9'b010011010);
        end
        step();
    endtask

    task automatic test_bad_crc();
        do_start(1'b0, 1'b0);
        vectors++;
        if (ack_drive !== 1'b0) begin
            miscompares++;
            $display("FAIL badcrc_drive: got %b want 0", ack_drive);
        end
        do_sample(1'b1);
        do_sample(1'b1);
        vectors++;
        if (outs !== 9'b0_10_0_01000) begin
            miscompares++;
            $display("FAIL badcrc_done: got %b want %b", outs, 9'b010001000);
        end
        step();
    endtask

    task automatic test_timeout();
        int hit;
        hit = 0;
        do_start(1'b0, 1'b1);
        for (int i = 1; i <= 20 && hit == 0; i++) begin
            step();
            if (timeout === 1'b1) hit = i;
        end
        vectors++;
        if (hit != 8) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d want 8 cycles", hit);
        end
        if (hit != 0) begin
            // only timeout set, ack_drive dropped, idle
            vectors++;
            if (outs !== 9'b0_00_0_00001) begin
                miscompares++;
                $display("FAIL timeout_outs: got %b want %b", outs, 9'b000000001);
            end
            step();
            vectors++;
            if (timeout !== 1'b0 || ack_complete !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_pulse_width: got timeout=%b complete=%b want 0 0", timeout, ack_complete);
            end
        end
    endtask

    task automatic test_timeout_clear();
        do_start(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step();
        do_sample(1'b0);
        for (int i = 0; i < 7; i++) step();
        vectors++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_restart_early: got timeout=%b busy=%b want 0 1", timeout, busy);
        end
        step();
        vectors++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_restart_fire: got timeout=%b busy=%b want 1 0", timeout, busy);
        end
        step();
    endtask

    task automatic test_abort_restart();
        do_start(1'b0, 1'b1);
        step();
        vectors++;
        if (ack_drive !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre_drive: got %b want 1", ack_drive);
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        vectors++;
        if (outs !== 9'b0) begin
            miscompares++;
            $display("FAIL abort_reset_outs: got %b want %b", outs, 9'b0);
        end
        do_start(1'b1, 1'b1);
        do_sample(1'b1);
        do_sample(1'b1);
        vectors++;
        if (outs !== 9'b0_10_0_01100) begin
            miscompares++;
            $display("FAIL restart_done: got %b want %b", outs, 9'b010001100);
        end
        step();
        do_start(1'b0, 1'b1);
        enable = 1'b0;
        step();
        enable = 1'b1;
        vectors++;
        if (outs !== 9'b0) begin
            miscompares++;
            $display("FAIL enable_abort_outs: got %b want %b", outs, 9'b0);
        end
        do_sample(1'b0);
        vectors++;
        if (busy !== 1'b0 || bit_counter !== 2'd0) begin
            miscompares++;
            $display("FAIL idle_sample_ignored: got busy=%b bc=%0d want 0 0", busy, bit_counter);
        end
    endtask

    task automatic test_back_to_back();
        do_start(1'b0, 1'b1);
        do_sample(1'b0);
        do_start(1'b1, 1'b0);
        vectors++;
        if (outs !== 9'b0_01_1_10000) begin
            miscompares++;
            $display("FAIL restart_midfield_ignored: got %b want %b", outs, 9'b001110000);
        end
        do_sample(1'b1);
        vectors++;
        if (outs !== 9'b0_10_0_11000) begin
            miscompares++;
            $display("FAIL midfield_done: got %b want %b", outs, 9'b010011000);
        end
        is_transmitter = 1'b0;
        crc_ok = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if (outs !== 9'b0_00_0_10000) begin
            miscompares++;
            $display("FAIL start_in_done_ignored: got %b want %b", outs, 9'b000010000);
        end
        is_transmitter = 1'b0;
        crc_ok = 1'b1;
        start = 1'b1;
        sample_point = 1'b1;
        rx_bit = 1'b1;
        step();
        start = 1'b0;
        sample_point = 1'b0;
        vectors++;
        if (outs !== 9'b1_00_1_00000) begin
            miscompares++;
            $display("FAIL start_with_sample: got %b want %b", outs, 9'b100100000);
        end
        do_sample(1'b0);
        vectors++;
        if (outs !== 9'b0_01_1_10000) begin
            miscompares++;
            $display("FAIL start_with_sample_slot: got %b want %b", outs, 9'b001110000);
        end
        do_sample(1'b1);
        step();
    endtask

    initial begin
        test_reset();
        test_receiver_ack();
        test_tx_no_ack();
        test_form_error();
        test_bad_crc();
        test_timeout();
        test_timeout_clear();
        test_abort_restart();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ack_field_rx.md
Name: ack_field_rx

Overview:
- Receive/checking end of the CAN ACK field; counterpart to the transmit-side ACK field generator.
- Started by the CRC stage once the CRC delimiter has been sampled. Walks the ACK slot and ACK delimiter on `sample_point`.
- As a receiving node with a good CRC, it drives a dominant ACK in the slot. As the transmitting node, it checks that some node acknowledged.
- Checks the delimiter for a form error and reports results to the frame controller and the error-confinement logic.

Parameters:
- TIMEOUT_CYCLES, 1023, maximum clock cycles allowed between consecutive `sample_point` pulses while busy; must be ≥ 1.
- TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter. Derived; do not override.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  block enable; low = synchronous return to IDLE with reset output values.
- sample_point  in  1  one-cycle pulse at the bit sample point.
- rx_bit  in  1  sampled bus level; 0 = dominant.
- start  in  1  one-cycle pulse: CRC delimiter done, ACK slot is the next bit.
- is_transmitter  in  1  this node sent the frame; latched on start.
- crc_ok  in  1  received CRC matched; latched on start.
- ack_drive  out  1  1 = drive dominant on the bus during the ACK slot.
- bit_counter  out  2  ACK-field bits sampled so far (0..2).
- busy  out  1  high in ACK_SLOT or ACK_DELIM.
- ack_seen  out  1  dominant sampled in the slot; sticky until the next start.
- ack_complete  out  1  one-cycle pulse at the end of the field.
- ack_error  out  1  one-cycle pulse with ack_complete: transmitter and no ACK seen.
- form_error  out  1  one-cycle pulse with ack_complete: delimiter sampled dominant.
- timeout  out  1  one-cycle pulse: the field was aborted.

Behaviour:
- **Reset values.** On reset_n low, or enable low, at a clock edge:
  - state = IDLE.
  - All outputs 0.
  - Latched `is_transmitter` / `crc_ok` cleared.
  - Timeout counter cleared.
- **All outputs are registered.**
- **States.** IDLE, ACK_SLOT, ACK_DELIM, DONE. Encoding is in the package.
- **IDLE.**
  - A `start` pulse moves to ACK_SLOT on the next edge.
  - The same edge latches `is_transmitter` and `crc_ok`, clears `ack_seen`, `bit_counter` and the timeout counter.
  - The same edge sets `ack_drive` = !is_transmitter && crc_ok, so it is valid 1 cycle after `start`.
- **ACK_SLOT.**
  - On `sample_point`: `ack_seen` <= !rx_bit, `bit_counter` <= 1, `ack_drive` <= 0, move to ACK_DELIM.
  - `ack_drive` is held for the whole slot up to and including the sample cycle.
- **ACK_DELIM.**
  - On `sample_point`: `bit_counter` <= 2, latch delimiter error = !rx_bit, move to DONE.
  - `ack_drive` is always 0 here.
- **DONE (exactly 1 cycle).**
  - `ack_complete` = 1.
  - `ack_error` = latched is_transmitter && !ack_seen.
  - `form_error` = latched delimiter error.
  - Next state IDLE. `bit_counter` returns to 0 on exit; `ack_seen` stays until the next `start`.
- **Timeout.**
  - In ACK_SLOT/ACK_DELIM the counter increments each cycle without `sample_point` and clears on `sample_point`.
  - When it reaches TIMEOUT_CYCLES: pulse `timeout` for 1 cycle, `ack_drive` <= 0, go to IDLE.
  - No `ack_complete`, `ack_error` or `form_error` is asserted.
- **Simultaneous events.**
  - `start` while busy or in DONE: ignored.
  - `start` together with `sample_point` in IDLE: only `start` acts; that sample point belongs to the CRC delimiter.
  - `sample_point` in IDLE/DONE: ignored.
- **Mid-field abort.** enable or reset low mid-field aborts immediately: `ack_drive` drops on the same edge and no completion or error pulse is produced.
- **Self-ACK.** A transmitter never drives ACK, even when crc_ok = 1.
- **Receiver with bad CRC.** A receiver with crc_ok = 0 does not drive ACK; `ack_error` stays 0. CRC error reporting belongs to the CRC stage.

Decomposition:
- **Package can_pkg:**
  - `ack_rx_state_t` enum (2-bit).
  - Constants DOMINANT = 1'b0, RECESSIVE = 1'b1.
  - ACK_FIELD_BITS = 2.
- **Sub-module:** one natural sub-module, `bit_timeout_counter` (param TIMEOUT_CYCLES; inputs run, clear; output expired). The state machine stays in the top level.

Test Plan:
- **Receiver ACK:** start with is_transmitter = 0, crc_ok = 1; rx_bit = 0 at slot sample, 1 at delimiter.
  - ack_drive = 1 from start+1 through the slot sample cycle, then 0.
  - ack_seen = 1; ack_complete pulses once; ack_error = 0, form_error = 0; bit_counter 0→1→2→0.
- **Transmitter, no ACK:** is_transmitter = 1, crc_ok = 1, rx_bit = 1 at both samples.
  - ack_drive stays 0; ack_error = 1 coincident with ack_complete; ack_seen = 0.
- **Form error:** receiver, crc_ok = 1, slot dominant, delimiter rx_bit = 0.
  - form_error = 1 with ack_complete; ack_error = 0.
- **Timeout:** TIMEOUT_CYCLES = 8; start, then no sample_point.
  - timeout pulses exactly 8 cycles after entering ACK_SLOT; ack_drive drops to 0; state IDLE; no ack_complete.
- **Abort and restart:** reset_n = 0 for 1 cycle during the slot while ack_drive = 1.
  - Next cycle: all outputs 0.
  - A new start with is_transmitter = 1 gives a clean field with no stale ack_seen.
- **Simultaneous events:**
  - A second start mid-field is ignored; bit_counter continues.
  - start + sample_point in the same IDLE cycle: the slot sample is taken on the next sample_point, not the coincident one.
